// File: rtl/ad_bus_pkg.sv
// Shared types and default timing for the multiplexed AD bus transfer controller.
package ad_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_HOLD,
    ST_STROBE,
    ST_RECOV,
    ST_DONE
  } state_e;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_T_ALE    = 2;
  localparam int unsigned DEF_T_HOLD   = 1;
  localparam int unsigned DEF_T_STROBE = 3;
  localparam int unsigned DEF_T_REC    = 2;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ad_phase_timer.sv
// Loadable down-counter that stops at zero; o_zero_c flags the last cycle of a phase.
module ad_phase_timer #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/ad_bus_xfer_ctrl.sv
// Runs one complete ALE/CS/RD/WR cycle on the multiplexed AD bus per accepted host request.
// All pins come from registers computed from the next state, so they line up with the phase.
module ad_bus_xfer_ctrl
  import ad_bus_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned T_ALE    = DEF_T_ALE,
  parameter int unsigned T_HOLD   = DEF_T_HOLD,
  parameter int unsigned T_STROBE = DEF_T_STROBE,
  parameter int unsigned T_REC    = DEF_T_REC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  inout  wire  [DATA_W-1:0] ad,
  output logic              cs_n,
  output logic              ale,
  output logic              rd_n,
  output logic              wr_n
);

  localparam int unsigned T_MAX = max_u(max_u(T_ALE, T_HOLD), max_u(T_STROBE, T_REC));
  localparam int unsigned CNT_W = $clog2(T_MAX) + 1;

  state_e              r_state, w_nxt_state;
  logic                w_load, w_zero_c, w_capture;
  logic [CNT_W-1:0]    w_load_val;
  logic                r_rw;
  logic [DATA_W-1:0]   r_addr, r_wdata, r_rdata, r_ad_out;
  logic [DATA_W-1:0]   w_addr, w_ad_out;
  logic                r_cs_n, r_ale, r_rd_n, r_wr_n, r_oe, r_busy, r_done;
  logic                w_cs_n, w_ale, w_rd_n, w_wr_n, w_oe;

  ad_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero_c   (w_zero_c)
  );

  // Next state, phase timer load, and next-cycle pin values
  always_comb begin
    w_nxt_state = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    case (r_state)
      ST_IDLE: if (req) begin
        w_nxt_state = ST_ADDR;
        w_load      = 1'b1;
        w_load_val  = CNT_W'(T_ALE - 1);
      end
      ST_ADDR: if (w_zero_c) begin
        w_nxt_state = ST_HOLD;
        w_load      = 1'b1;
        w_load_val  = CNT_W'(T_HOLD - 1);
      end
      ST_HOLD: if (w_zero_c) begin
        w_nxt_state = ST_STROBE;
        w_load      = 1'b1;
        w_load_val  = CNT_W'(T_STROBE - 1);
      end
      ST_STROBE: if (w_zero_c) begin
        w_nxt_state = ST_RECOV;
        w_load      = 1'b1;
        w_load_val  = CNT_W'(T_REC - 1);
      end
      ST_RECOV: if (w_zero_c) begin
        w_nxt_state = ST_DONE;
        w_load      = 1'b1;
      end
      ST_DONE:  w_nxt_state = ST_IDLE;
      default:  w_nxt_state = ST_IDLE;
    endcase

    // On the accepting edge the address register is not yet loaded
    w_addr    = (r_state == ST_IDLE) ? addr : r_addr;
    w_cs_n    = !(w_nxt_state inside {ST_ADDR, ST_HOLD, ST_STROBE});
    w_ale     = (w_nxt_state == ST_ADDR);
    w_rd_n    = !((w_nxt_state == ST_STROBE) && (r_rw == RW_READ));
    w_wr_n    = !((w_nxt_state == ST_STROBE) && (r_rw == RW_WRITE));
    w_oe      = (w_nxt_state inside {ST_ADDR, ST_HOLD}) ||
                ((w_nxt_state == ST_STROBE) && (r_rw == RW_WRITE)) ||
                ((w_nxt_state == ST_RECOV) && (r_state == ST_STROBE) && (r_rw == RW_WRITE));
    w_ad_out  = (w_nxt_state inside {ST_ADDR, ST_HOLD}) ? w_addr : r_wdata;
    w_capture = (r_state == ST_STROBE) && w_zero_c && (r_rw == RW_READ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_rw     <= RW_READ;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_ad_out <= '0;
      r_cs_n   <= 1'b1;
      r_ale    <= 1'b0;
      r_rd_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_oe     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_ad_out <= w_ad_out;
      r_cs_n   <= w_cs_n;
      r_ale    <= w_ale;
      r_rd_n   <= w_rd_n;
      r_wr_n   <= w_wr_n;
      r_oe     <= w_oe;
      r_busy   <= (w_nxt_state != ST_IDLE);
      r_done   <= (w_nxt_state == ST_DONE);
      if ((r_state == ST_IDLE) && req) begin
        r_rw    <= rw;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      // Sample the slave's data while rd_n is still low
      if (w_capture) begin
        r_rdata <= ad;
      end
    end
  end

  assign ad    = r_oe ? r_ad_out : {DATA_W{1'bz}};
  assign cs_n  = r_cs_n;
  assign ale   = r_ale;
  assign rd_n  = r_rd_n;
  assign wr_n  = r_wr_n;
  assign busy  = r_busy;
  assign done  = r_done;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_ad_bus_xfer_ctrl.sv
// Directed bench for ad_bus_xfer_ctrl: default 8-bit instance plus a 16-bit timing variant.
module tb_ad_bus_xfer_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        req, rw;
  logic [7:0]  addr, wdata, rdata;
  wire  [7:0]  ad8;
  logic        busy, done, cs_n, ale, rd_n, wr_n;
  logic [7:0]  r_rd_val;
  logic        r_probe;

  logic        req16, rw16;
  logic [15:0] addr16, wdata16, rdata16;
  wire  [15:0] ad16;
  logic        busy16, done16, cs16_n, ale16, rd16_n, wr16_n;

  int n_tests;
  int n_fail;

  always #5 clk = ~clk;

  // Slave model: drives read data while rd_n is low; optional probe value to detect a released bus
  assign ad8  = (!rd_n) ? r_rd_val : (r_probe ? 8'h33 : 8'hzz);
  assign ad16 = (!rd16_n) ? 16'hBEEF : 16'hzzzz;

  ad_bus_xfer_ctrl u_dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .ad(ad8),
    .cs_n(cs_n), .ale(ale), .rd_n(rd_n), .wr_n(wr_n)
  );

  ad_bus_xfer_ctrl #(
    .DATA_W(16), .T_ALE(1), .T_HOLD(2), .T_STROBE(1), .T_REC(1)
  ) u_dut16 (
    .clk(clk), .reset(reset), .req(req16), .rw(rw16), .addr(addr16), .wdata(wdata16),
    .busy(busy16), .done(done16), .rdata(rdata16), .ad(ad16),
    .cs_n(cs16_n), .ale(ale16), .rd_n(rd16_n), .wr_n(wr16_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic probe_hiz(input string tag);
    r_probe = 1'b1;
    #1;
    check(tag, 32'(ad8), 32'h33);
    r_probe = 1'b0;
  endtask

  // One full default-timing transfer; cycle i is the i-th cycle after the accepting edge
  task automatic xfer(input string nm, input logic wr, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] rv, input bit disturb, input bit keep_req,
                      input logic [7:0] rd_prev);
    rw = wr; addr = a; wdata = d; r_rd_val = rv; req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick;
      if (i == 1 && !keep_req) req = 1'b0;
      check($sformatf("%s ale c%0d", nm, i),  32'(ale),  32'(i <= 2));
      check($sformatf("%s cs_n c%0d", nm, i), 32'(cs_n), 32'(i > 6));
      check($sformatf("%s rd_n c%0d", nm, i), 32'(rd_n), 32'(!(!wr && i >= 4 && i <= 6)));
      check($sformatf("%s wr_n c%0d", nm, i), 32'(wr_n), 32'(!(wr && i >= 4 && i <= 6)));
      check($sformatf("%s busy c%0d", nm, i), 32'(busy), 32'(i <= 9));
      check($sformatf("%s done c%0d", nm, i), 32'(done), 32'(i == 9));
      if (i <= 3)
        check($sformatf("%s ad addr c%0d", nm, i), 32'(ad8), 32'(a));
      else if (i <= 6)
        check($sformatf("%s ad data c%0d", nm, i), 32'(ad8), 32'(wr ? d : rv));
      else if (i == 7 && wr)
        check($sformatf("%s ad whold c%0d", nm, i), 32'(ad8), 32'(d));
      else
        probe_hiz($sformatf("%s ad hiz c%0d", nm, i));
      check($sformatf("%s rdata c%0d", nm, i), 32'(rdata), 32'((!wr && i >= 7) ? rv : rd_prev));
      if (disturb) begin
        case (i)
          2: begin addr = 8'h44; wdata = 8'h55; req = 1'b1; end
          3: req = 1'b0;
          5: req = 1'b1;
          6: req = 1'b0;
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    int n_done;
    n_tests = 0; n_fail = 0;
    req = 1'b0; rw = 1'b0; addr = '0; wdata = '0; r_rd_val = '0; r_probe = 1'b0;
    req16 = 1'b0; rw16 = 1'b0; addr16 = '0; wdata16 = '0;

    reset = 1'b1;
    tick; tick;
    check("rst cs_n", 32'(cs_n), 32'd1);
    check("rst ale", 32'(ale), 32'd0);
    check("rst rd_n", 32'(rd_n), 32'd1);
    check("rst wr_n", 32'(wr_n), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst rdata", 32'(rdata), 32'd0);
    check("rst rdata16", 32'(rdata16), 32'd0);
    probe_hiz("rst ad hiz");
    reset = 1'b0;
    tick;

    // Reset pulse in the second strobe cycle of a read
    rw = 1'b0; addr = 8'h0C; r_rd_val = 8'hA7; req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick;
      if (i == 1) req = 1'b0;
    end
    check("abort rd_n before", 32'(rd_n), 32'd0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("abort cs_n", 32'(cs_n), 32'd1);
    check("abort rd_n", 32'(rd_n), 32'd1);
    check("abort ale", 32'(ale), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    probe_hiz("abort ad hiz");
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done) n_done++;
    end
    check("abort done count", 32'(n_done), 32'd0);
    check("abort rdata", 32'(rdata), 32'd0);

    xfer("wr", 1'b1, 8'h0A, 8'h5C, 8'h00, 1'b0, 1'b0, 8'h00);
    xfer("rd", 1'b0, 8'h0C, 8'h00, 8'hA7, 1'b0, 1'b0, 8'h00);

    // Back-to-back: req held high, second accept right after the idle cycle
    xfer("b2b", 1'b1, 8'h01, 8'h11, 8'h00, 1'b0, 1'b1, 8'hA7);
    tick;
    req = 1'b0;
    check("b2b 2nd busy", 32'(busy), 32'd1);
    check("b2b 2nd ale", 32'(ale), 32'd1);
    check("b2b 2nd ad", 32'(ad8), 32'h01);
    for (int i = 12; i <= 20; i++) begin
      tick;
      check($sformatf("b2b2 done c%0d", i), 32'(done), 32'(i == 19));
      check($sformatf("b2b2 busy c%0d", i), 32'(busy), 32'(i <= 19));
    end
    check("b2b rdata kept", 32'(rdata), 32'hA7);

    xfer("ign", 1'b1, 8'h22, 8'h33, 8'h00, 1'b1, 1'b0, 8'hA7);

    // 16-bit variant with T_ALE=1 T_HOLD=2 T_STROBE=1 T_REC=1
    rw16 = 1'b0; addr16 = 16'h0030; req16 = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick;
      if (i == 1) req16 = 1'b0;
      check($sformatf("v16 done c%0d", i), 32'(done16), 32'(i == 6));
      check($sformatf("v16 busy c%0d", i), 32'(busy16), 32'(i <= 6));
      check($sformatf("v16 ale c%0d", i),  32'(ale16),  32'(i == 1));
      check($sformatf("v16 rd_n c%0d", i), 32'(rd16_n), 32'(i != 4));
      check($sformatf("v16 cs_n c%0d", i), 32'(cs16_n), 32'(i >= 5));
      if (i <= 3) check($sformatf("v16 ad c%0d", i), 32'(ad16), 32'h0030);
      check($sformatf("v16 rdata c%0d", i), 32'(rdata16), (i >= 5) ? 32'hBEEF : 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
